// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants (SXGA@60 Hz defaults) and the 11-bit coordinate type
// consumed by the scan generator and the cell-display decoder.
package vga_timing_pkg;

  localparam int unsigned COORD_W         = 11;
  localparam int unsigned COORD_MAX_TOTAL = 2 ** COORD_W;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COORD_W:0]   coord_ext_t;

  localparam int unsigned SXGA_H_VIS   = 1280;
  localparam int unsigned SXGA_H_FP    = 48;
  localparam int unsigned SXGA_H_SYNC  = 112;
  localparam int unsigned SXGA_H_BP    = 248;
  localparam int unsigned SXGA_H_TOTAL = SXGA_H_VIS + SXGA_H_FP + SXGA_H_SYNC + SXGA_H_BP;

  localparam int unsigned SXGA_V_VIS   = 1024;
  localparam int unsigned SXGA_V_FP    = 1;
  localparam int unsigned SXGA_V_SYNC  = 3;
  localparam int unsigned SXGA_V_BP    = 38;
  localparam int unsigned SXGA_V_TOTAL = SXGA_V_VIS + SXGA_V_FP + SXGA_V_SYNC + SXGA_V_BP;

  function automatic bit total_fits(input int unsigned total);
    return (total >= 2) && (total <= COORD_MAX_TOTAL);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with enable, terminal-count flag,
// registered sync level and a look-ahead visible flag for the top's aligned registers.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned TOTAL   = SXGA_H_TOTAL,
  parameter int unsigned VIS     = SXGA_H_VIS,
  parameter int unsigned SYNC_LO = SXGA_H_VIS + SXGA_H_FP,
  parameter int unsigned SYNC_HI = SXGA_H_VIS + SXGA_H_FP + SXGA_H_SYNC,
  parameter bit          POL     = 1'b1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  output coord_t count,
  output logic   tc,
  output logic   vis_nxt,
  output logic   sync
);

  localparam coord_t     LAST  = coord_t'(TOTAL - 1);
  localparam coord_ext_t VIS_E = coord_ext_t'(VIS);
  localparam coord_ext_t LO_E  = coord_ext_t'(SYNC_LO);
  localparam coord_ext_t HI_E  = coord_ext_t'(SYNC_HI);

  coord_t nxt;
  logic   sync_nxt;

  assign tc = (count == LAST);

  // Decode on the next count so registered flags line up with the registered count.
  always_comb begin
    nxt = count;
    if (en) nxt = tc ? '0 : count + coord_t'(1);
    vis_nxt  = ({1'b0, nxt} < VIS_E);
    sync_nxt = ({1'b0, nxt} >= LO_E) && ({1'b0, nxt} < HI_E);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= LAST;
      sync  <= ~POL;
    end else begin
      count <= nxt;
      sync  <= sync_nxt ? POL : ~POL;
    end
  end

endmodule

// File: rtl/vga_scan_gen.sv
// Raster scan generator: x/y sweep, hsync/vsync, visible/vblank flags and frame pulse.
// Optional LIFE_STEP_EN adds a frame counter and a once-per-STEP_FRAMES vblank step pulse.
module vga_scan_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VIS       = SXGA_H_VIS,
  parameter int unsigned H_FP        = SXGA_H_FP,
  parameter int unsigned H_SYNC      = SXGA_H_SYNC,
  parameter int unsigned H_BP        = SXGA_H_BP,
  parameter int unsigned V_VIS       = SXGA_V_VIS,
  parameter int unsigned V_FP        = SXGA_V_FP,
  parameter int unsigned V_SYNC      = SXGA_V_SYNC,
  parameter int unsigned V_BP        = SXGA_V_BP,
  parameter bit          SYNC_POL    = 1'b1,
  parameter int unsigned STEP_FRAMES = 30
) (
  input  logic   clk,
  input  logic   rst,
  output coord_t x,
  output coord_t y,
  output logic   hsync,
  output logic   vsync,
  output logic   video_on,
  output logic   frame_start,
  output logic   vblank
`ifdef LIFE_STEP_EN
  ,
  output logic   step
`endif
);

  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  if (!total_fits(H_TOTAL)) begin : g_h_total_chk
    $error("vga_scan_gen: H_TOTAL must be 2..2048");
  end
  if (!total_fits(V_TOTAL)) begin : g_v_total_chk
    $error("vga_scan_gen: V_TOTAL must be 2..2048");
  end
  if (STEP_FRAMES < 1 || STEP_FRAMES > 256) begin : g_step_chk
    $error("vga_scan_gen: STEP_FRAMES must be 1..256");
  end

  logic h_tc, v_tc, h_vis_nxt, v_vis_nxt;

  vga_axis_counter #(
    .TOTAL   (H_TOTAL),
    .VIS     (H_VIS),
    .SYNC_LO (H_VIS + H_FP),
    .SYNC_HI (H_VIS + H_FP + H_SYNC),
    .POL     (SYNC_POL)
  ) u_h (
    .clk     (clk),
    .rst     (rst),
    .en      (1'b1),
    .count   (x),
    .tc      (h_tc),
    .vis_nxt (h_vis_nxt),
    .sync    (hsync)
  );

  vga_axis_counter #(
    .TOTAL   (V_TOTAL),
    .VIS     (V_VIS),
    .SYNC_LO (V_VIS + V_FP),
    .SYNC_HI (V_VIS + V_FP + V_SYNC),
    .POL     (SYNC_POL)
  ) u_v (
    .clk     (clk),
    .rst     (rst),
    .en      (h_tc),
    .count   (y),
    .tc      (v_tc),
    .vis_nxt (v_vis_nxt),
    .sync    (vsync)
  );

  // Both axes at terminal count means the next pixel is (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      video_on    <= 1'b0;
      frame_start <= 1'b0;
      vblank      <= 1'b1;
    end else begin
      video_on    <= h_vis_nxt & v_vis_nxt;
      frame_start <= h_tc & v_tc;
      vblank      <= ~v_vis_nxt;
    end
  end

`ifdef LIFE_STEP_EN
  localparam logic [7:0] STEP_LAST = 8'(STEP_FRAMES - 1);
  localparam coord_t     V_PRE     = coord_t'(V_VIS - 1);

  logic [7:0] frame_cnt;

  // step lands on the transition into (0,V_VIS), i.e. the first vblank pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      step      <= 1'b0;
    end else begin
      if (frame_start) frame_cnt <= (frame_cnt == STEP_LAST) ? '0 : frame_cnt + 8'd1;
      step <= h_tc && (y == V_PRE) && (frame_cnt == STEP_LAST);
    end
  end
`endif

endmodule

// File: tb/tb_vga_scan_gen.sv
// Scoreboard bench for vga_scan_gen on a reduced raster (25x14); a second instance
// with inverted sync polarity runs in lock-step.
module tb_vga_scan_gen;

  localparam int HV = 16, HFP = 2, HS = 3, HBP = 4, HT = HV + HFP + HS + HBP;
  localparam int VV = 8,  VFP = 1, VS = 2, VBP = 3, VT = VV + VFP + VS + VBP;
  localparam int SF = 3;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [10:0] x, y, x_n, y_n;
  logic hsync, vsync, video_on, frame_start, vblank;
  logic hsync_n, vsync_n, video_on_n, frame_start_n, vblank_n;
`ifdef LIFE_STEP_EN
  logic step, step_n;
`endif

  vga_scan_gen #(
    .H_VIS(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_VIS(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(1'b1), .STEP_FRAMES(SF)
  ) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .hsync(hsync), .vsync(vsync),
    .video_on(video_on), .frame_start(frame_start), .vblank(vblank)
`ifdef LIFE_STEP_EN
    , .step(step)
`endif
  );

  vga_scan_gen #(
    .H_VIS(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_VIS(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(1'b0), .STEP_FRAMES(SF)
  ) dut_n (
    .clk(clk), .rst(rst), .x(x_n), .y(y_n), .hsync(hsync_n), .vsync(vsync_n),
    .video_on(video_on_n), .frame_start(frame_start_n), .vblank(vblank_n)
`ifdef LIFE_STEP_EN
    , .step(step_n)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, act, exp, $time);
  endtask

  typedef struct {
    int x; int y;
    bit hs; bit vs; bit von; bit fs; bit vb; bit st;
  } exp_t;

  exp_t sb[$];

  int mx, my, fc;
  bit fs_prev;

  // Reference raster: advance one clock edge and queue the expected outputs.
  task automatic model_edge(input bit r);
    exp_t e;
    if (r) begin
      mx = HT - 1; my = VT - 1; fc = 0; fs_prev = 1'b0;
    end else begin
      if (fs_prev) fc = (fc == SF - 1) ? 0 : fc + 1;
      mx++;
      if (mx == HT) begin
        mx = 0; my++;
        if (my == VT) my = 0;
      end
    end
    e.x   = mx;
    e.y   = my;
    e.fs  = !r && mx == 0 && my == 0;
    e.hs  = !r && mx >= HV + HFP && mx < HV + HFP + HS;
    e.vs  = !r && my >= VV + VFP && my < VV + VFP + VS;
    e.von = !r && mx < HV && my < VV;
    e.vb  = r || my >= VV;
    e.st  = !r && mx == 0 && my == VV && fc == SF - 1;
    fs_prev = e.fs;
    sb.push_back(e);
  endtask

  bit clean = 1'b0;
  int per_cyc, per_von, per_vs, per_vb, per_hs;

  task automatic sample();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    check("x", int'(x), e.x);
    check("y", int'(y), e.y);
    check("hsync", int'(hsync), int'(e.hs));
    check("vsync", int'(vsync), int'(e.vs));
    check("video_on", int'(video_on), int'(e.von));
    check("frame_start", int'(frame_start), int'(e.fs));
    check("vblank", int'(vblank), int'(e.vb));
    check("hsync_n", int'(hsync_n), int'(!e.hs));
    check("vsync_n", int'(vsync_n), int'(!e.vs));
    check("misc_n", int'({x_n, y_n, video_on_n, frame_start_n, vblank_n}),
          int'({e.x[10:0], e.y[10:0], e.von, e.fs, e.vb}));
`ifdef LIFE_STEP_EN
    check("step", int'(step), int'(e.st));
    check("step_n", int'(step_n), int'(e.st));
`endif
    if (rst) clean = 1'b0;
    if (frame_start) begin
      if (clean) begin
        check("frame_period", per_cyc, FRAME);
        check("von_per_frame", per_von, HV * VV);
        check("vsync_per_frame", per_vs, VS * HT);
        check("vblank_per_frame", per_vb, (VT - VV) * HT);
        check("hsync_per_frame", per_hs, HS * VT);
      end
      clean = !rst;
      per_cyc = 0; per_von = 0; per_vs = 0; per_vb = 0; per_hs = 0;
    end
    per_cyc++;
    per_von += int'(video_on);
    per_vs  += int'(vsync);
    per_vb  += int'(vblank);
    per_hs  += int'(hsync);
  endtask

  task automatic run(input int n, input bit r);
    repeat (n) begin
      rst = r;
      model_edge(r);
      @(posedge clk);
      #1;
      sample();
    end
  endtask

  initial begin
    int guard;
    run(5, 1'b1);
    run(4 * FRAME + 50, 1'b0);

    guard = 0;
    while (!(mx == 10 && my == 5) && guard < 2 * FRAME) begin
      run(1, 1'b0);
      guard++;
    end
    check("seek_mid_frame", mx * 100 + my, 1005);

    // Asynchronous reset between clock edges.
    rst   = 1'b1;
    clean = 1'b0;
    #1;
    check("async_x", int'(x), HT - 1);
    check("async_y", int'(y), VT - 1);
    check("async_video_on", int'(video_on), 0);
    check("async_frame_start", int'(frame_start), 0);
    check("async_vblank", int'(vblank), 1);
    check("async_sync", int'({hsync, vsync}), 0);
    check("async_sync_n", int'({hsync_n, vsync_n}), 3);

    run(3, 1'b1);
    run(3 * FRAME + 20, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
